// File: rtl/network_controller_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg: shared definitions for the step-activation network controller.
//   state_e    - controller FSM states (IDLE, LOAD, MAC, DONE)
//   W_WIDTH    - signed width of each weight and input element
//   ACC_WIDTH  - signed accumulator width (4 products of 8x8 cannot overflow)
//   NUM_UNITS  - number of neurons (one 32-bit weight word each)
//   NUM_INPUTS - inputs per neuron (NUM_INPUTS*W_WIDTH == 32)
// -----------------------------------------------------------------------------
package nn_pkg;

    localparam int unsigned W_WIDTH    = 8;
    localparam int unsigned ACC_WIDTH  = 18;
    localparam int unsigned NUM_UNITS  = 4;
    localparam int unsigned NUM_INPUTS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_DONE
    } state_e;

endpackage

// File: rtl/network_controller_if.sv
// -----------------------------------------------------------------------------
// network_controller_if: host-side bus of the network controller.
//   weight_data  - packed weight word, byte k is the signed weight for input k
//   weight_addr  - unit index for a weight write
//   write_weight - level write strobe, sampled every cycle
//   start        - request one evaluation pass
//   in_data      - packed signed inputs, byte k is x[k]
//   result       - registered step outputs, bit u for unit u
//   busy         - evaluation in progress (LOAD or MAC)
//   done         - one-cycle completion pulse
//   write_err    - sticky flag: a weight write arrived while busy
// master = host side, slave = controller side.
// -----------------------------------------------------------------------------
interface network_controller_if #(
    parameter int unsigned NUM_UNITS = nn_pkg::NUM_UNITS
);
    logic [31:0]                  weight_data;
    logic [$clog2(NUM_UNITS)-1:0] weight_addr;
    logic                         write_weight;
    logic                         start;
    logic [31:0]                  in_data;
    logic [NUM_UNITS-1:0]         result;
    logic                         busy;
    logic                         done;
    logic                         write_err;

    modport master (
        output weight_data, weight_addr, write_weight, start, in_data,
        input  result, busy, done, write_err
    );

    modport slave (
        input  weight_data, weight_addr, write_weight, start, in_data,
        output result, busy, done, write_err
    );
endinterface

// File: rtl/network_controller_mac.sv
// -----------------------------------------------------------------------------
// mac_unit: combinational multiply-accumulate step plus step activation.
//   acc_i      - running signed sum
//   w_i, x_i   - signed weight and input element
//   acc_next_o - acc_i + w_i*x_i
//   fire_o     - acc_next_o strictly greater than THRESHOLD
// -----------------------------------------------------------------------------
module mac_unit #(
    parameter int unsigned W_WIDTH   = nn_pkg::W_WIDTH,
    parameter int unsigned ACC_WIDTH = nn_pkg::ACC_WIDTH,
    parameter int          THRESHOLD = 0
) (
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    input  logic signed [W_WIDTH-1:0]   w_i,
    input  logic signed [W_WIDTH-1:0]   x_i,
    output logic signed [ACC_WIDTH-1:0] acc_next_o,
    output logic                        fire_o
);
    localparam logic signed [ACC_WIDTH-1:0] THR = ACC_WIDTH'(THRESHOLD);

    logic signed [2*W_WIDTH-1:0] prod;

    always_comb begin
        prod       = w_i * x_i;
        // Signed size cast sign-extends the product into the accumulator width.
        acc_next_o = acc_i + ACC_WIDTH'(prod);
        fire_o     = (acc_next_o > THR);
    end
endmodule

// File: rtl/network_controller.sv
// -----------------------------------------------------------------------------
// network_controller: sequential evaluator of NUM_UNITS step neurons.
// Holds the weight bank, FSM and unit/input counters; one MAC per cycle
// through mac_unit, so a pass is LOAD + NUM_UNITS*NUM_INPUTS MAC + DONE.
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - network_controller_if.slave (weights, start, inputs, status)
// Weight writes are accepted only in IDLE/DONE; writes while busy are dropped
// and flagged on write_err, which is cleared at the start of the next pass.
// -----------------------------------------------------------------------------
module network_controller
    import nn_pkg::*;
#(
    parameter int unsigned NUM_UNITS  = nn_pkg::NUM_UNITS,
    parameter int unsigned NUM_INPUTS = nn_pkg::NUM_INPUTS,
    parameter int unsigned W_WIDTH    = nn_pkg::W_WIDTH,
    parameter int          THRESHOLD  = 0
) (
    input  logic                clk,
    input  logic                reset,
    network_controller_if.slave bus
);
    localparam int unsigned AW = $clog2(NUM_UNITS);
    localparam int unsigned IW = $clog2(NUM_INPUTS);

    typedef logic [NUM_INPUTS-1:0][W_WIDTH-1:0] word_t;

    state_e                       state_q, state_d;
    word_t [NUM_UNITS-1:0]        w_q, w_d;
    word_t                        x_q, x_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [AW-1:0]                u_q, u_d;
    logic [IW-1:0]                i_q, i_d;
    logic [NUM_UNITS-1:0]         result_q, result_d;
    logic                         werr_q, werr_d;

    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic                         fire;
    logic                         last_i;
    logic                         last_u;

    assign last_i = (i_q == IW'(NUM_INPUTS - 1));
    assign last_u = (u_q == AW'(NUM_UNITS - 1));

    mac_unit #(
        .W_WIDTH   (W_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .THRESHOLD (THRESHOLD)
    ) u_mac (
        .acc_i      (acc_q),
        .w_i        (w_q[u_q][i_q]),
        .x_i        (x_q[i_q]),
        .acc_next_o (acc_next),
        .fire_o     (fire)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_MAC;
            ST_MAC:  if (last_i && last_u) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.busy = (state_q == ST_LOAD) || (state_q == ST_MAC);
        bus.done = (state_q == ST_DONE);
    end

    // Datapath next-state
    always_comb begin
        w_d      = w_q;
        x_d      = x_q;
        acc_d    = acc_q;
        u_d      = u_q;
        i_d      = i_q;
        result_d = result_q;
        werr_d   = werr_q;

        if (bus.write_weight && (state_q == ST_IDLE || state_q == ST_DONE))
            w_d[bus.weight_addr] = bus.weight_data;

        unique case (state_q)
            ST_LOAD: begin
                x_d    = bus.in_data;
                acc_d  = '0;
                u_d    = '0;
                i_d    = '0;
                werr_d = 1'b0;
            end
            ST_MAC: begin
                if (last_i) begin
                    result_d[u_q] = fire;
                    acc_d         = '0;
                    i_d           = '0;
                    u_d           = u_q + AW'(1);
                end else begin
                    acc_d = acc_next;
                    i_d   = i_q + IW'(1);
                end
            end
            default: ;
        endcase

        // A rejected write in LOAD wins over the LOAD-time clear.
        if (bus.write_weight && (state_q == ST_LOAD || state_q == ST_MAC))
            werr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q      <= '0;
            x_q      <= '0;
            acc_q    <= '0;
            u_q      <= '0;
            i_q      <= '0;
            result_q <= '0;
            werr_q   <= 1'b0;
        end else begin
            w_q      <= w_d;
            x_q      <= x_d;
            acc_q    <= acc_d;
            u_q      <= u_d;
            i_q      <= i_d;
            result_q <= result_d;
            werr_q   <= werr_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.write_err = werr_q;

endmodule

// File: tb/tb_network_controller.sv
module tb_network_controller;

    localparam int THRESH = 0;

    typedef logic [3:0][31:0] bank_t;

    typedef struct packed {
        bank_t       w;
        logic [31:0] x;
        logic [3:0]  exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    network_controller_if #(.NUM_UNITS(4)) bus ();

    network_controller #(
        .NUM_UNITS  (4),
        .NUM_INPUTS (4),
        .W_WIDTH    (8),
        .THRESHOLD  (THRESH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    bank_t mw;          // reference copy of the weight bank
    vec_t  vecs [6];

    // Reference: each unit's dot product in plain integers, then the step rule.
    function automatic logic [3:0] model(input bank_t w, input logic [31:0] x);
        logic [3:0] r;
        int s;
        for (int u = 0; u < 4; u++) begin
            s = 0;
            for (int k = 0; k < 4; k++)
                s += int'($signed(w[u][8*k +: 8])) * int'($signed(x[8*k +: 8]));
            r[u] = (s > THRESH);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input logic [1:0] a, input logic [31:0] d, input bit with_start);
        bus.weight_addr  = a;
        bus.weight_data  = d;
        bus.write_weight = 1'b1;
        bus.start        = with_start;
        tick;
        bus.write_weight = 1'b0;
        bus.start        = 1'b0;
        mw[a]            = d;
    endtask

    task automatic start_pass;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
    endtask

    // Called n0 cycles after the start edge; expects done exactly at cycle 18.
    // in_data is scrambled after the LOAD edge to prove it was latched.
    task automatic wait_done(input string name, input logic [3:0] exp, input int n0);
        int n;
        n = n0;
        check({name, " busy"}, 32'(bus.busy), 32'd1);
        while (!bus.done && n < 30) begin
            tick;
            bus.in_data = $urandom;
            n++;
        end
        check({name, " latency"}, 32'(n), 32'd18);
        check({name, " result"}, 32'(bus.result), 32'(exp));
        tick;
        check({name, " done pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rexp;
        logic [31:0] x;
        logic [31:0] d;
        logic [1:0]  a;
        int          nw;
        int          ph;

        bus.weight_data  = '0;
        bus.weight_addr  = '0;
        bus.write_weight = 1'b0;
        bus.start        = 1'b0;
        bus.in_data      = '0;
        mw               = '0;
        reset            = 1'b1;

        vecs[0] = '{w: {32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101},
                    x: 32'h01020304, exp: 4'b1111};
        vecs[1] = '{w: {32'h01010101, 32'hFFFFFFFF, 32'h01010101, 32'h01010101},
                    x: 32'h01020304, exp: 4'b1011};
        vecs[2] = '{w: {32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080},
                    x: 32'h80808080, exp: 4'b1111};
        vecs[3] = '{w: {32'h01010101, 32'h01010101, 32'h01010101, 32'h80808080},
                    x: 32'h7F7F7F7F, exp: 4'b1110};
        vecs[4] = '{w: {32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000},
                    x: 32'h12345678, exp: 4'b0000};
        // Sums +1, -1, 0, +1 straddle the zero threshold.
        vecs[5] = '{w: {32'h01000000, 32'h00000000, 32'h000000FF, 32'h00000001},
                    x: 32'h01000001, exp: 4'b1001};

        // Reset state
        #3;
        check("reset result", 32'(bus.result), 32'd0);
        check("reset busy/done/err", {29'd0, bus.busy, bus.done, bus.write_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick;

        // Directed vector table
        for (int v = 0; v < 6; v++) begin
            for (int u = 0; u < 4; u++) write_w(2'(u), vecs[v].w[u], 1'b0);
            bus.in_data = vecs[v].x;
            start_pass;
            wait_done($sformatf("vec%0d", v), vecs[v].exp, 1);
        end

        // Weight write during MAC (cycle T+5) is dropped and flagged
        for (int u = 0; u < 4; u++) write_w(2'(u), 32'h01010101, 1'b0);
        bus.in_data = 32'h01020304;
        start_pass;
        repeat (4) tick;
        bus.weight_addr  = 2'd3;
        bus.weight_data  = 32'hFFFFFFFF;
        bus.write_weight = 1'b1;
        tick;
        bus.write_weight = 1'b0;
        check("mac write err set", 32'(bus.write_err), 32'd1);
        wait_done("mac write pass", 4'b1111, 6);
        check("write err sticky", 32'(bus.write_err), 32'd1);
        bus.in_data = 32'h01020304;
        start_pass;
        tick;
        check("write err cleared", 32'(bus.write_err), 32'd0);
        wait_done("after dropped write", 4'b1111, 2);

        // Asynchronous reset mid-pass at T+10
        start_pass;
        repeat (9) tick;
        #2;
        reset = 1'b1;
        #1;
        check("async reset busy", 32'(bus.busy), 32'd0);
        check("async reset result", 32'(bus.result), 32'd0);
        check("async reset done/err", {30'd0, bus.done, bus.write_err}, 32'd0);
        mw = '0;
        repeat (3) begin
            tick;
            check("in reset done/busy", {30'd0, bus.done, bus.busy}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            tick;
            check("idle after reset", {30'd0, bus.done, bus.busy}, 32'd0);
        end
        bus.in_data = 32'h01020304;
        start_pass;
        wait_done("cleared weights", model(mw, 32'h01020304), 1);
        for (int u = 0; u < 4; u++) write_w(2'(u), 32'h01010101, 1'b0);
        bus.in_data = 32'h01020304;
        start_pass;
        wait_done("post reset reload", 4'b1111, 1);

        // start held high: one pass every 19 cycles (17 busy, DONE, IDLE)
        write_w(2'd2, 32'hFFFFFFFF, 1'b0);
        bus.in_data = 32'h01020304;
        bus.start   = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick;
            ph = k % 19;
            check($sformatf("held start k=%0d", k), {30'd0, bus.done, bus.busy},
                  {30'd0, ph == 18, (ph >= 1 && ph <= 17)});
        end
        bus.start = 1'b0;
        check("held start result", 32'(bus.result), 32'(model(mw, 32'h01020304)));
        for (int k = 0; k < 30 && !bus.done; k++) tick;
        tick;

        // Randomized passes against the reference model
        for (int it = 0; it < 25; it++) begin
            x  = $urandom;
            bus.in_data = x;
            nw = $urandom_range(1, 8);
            for (int j = 0; j < nw; j++) begin
                a = 2'($urandom_range(0, 3));
                d = ($urandom_range(0, 3) == 0) ? 32'h80808080 : $urandom;
                write_w(a, d, (j == nw - 1) && (it % 2 == 1));
            end
            rexp = model(mw, x);
            if (it % 2 == 0) start_pass;
            wait_done($sformatf("rand%0d", it), rexp, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
